button_debouncer: RTL
=====================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 3: number of independent input channels.
REQ-002 SHALL have parameter STABLE_CYCLES, default 500000: clock cycles a synchronized level must hold before acceptance (10 ms at 50 MHz); legal range >= 1.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset; takes effect only on a rising edge of clock.
REQ-005 SHALL have port raw_in, input, WIDTH: asynchronous, bouncing pad levels (buttons, switches, board reset button).
REQ-006 SHALL have port debounced, output, WIDTH: registered, filtered level per channel; drives core gpio_input / reset logic.
REQ-007 SHALL have port rise, output, WIDTH: one-cycle registered pulse when debounced[i] goes 0->1.
REQ-008 SHALL have port fall, output, WIDTH: one-cycle registered pulse when debounced[i] goes 1->0.

Function
REQ-009 SHALL pass each raw_in[i] through a 2-flop synchronizer (sync1, sync2); only sync2 is used downstream.
REQ-010 SHALL keep one counter per channel, width clog2(STABLE_CYCLES+1), unsigned, no wrap: it never exceeds STABLE_CYCLES-1.
REQ-011 SHALL, per channel and edge, when sync2 == debounced: counter <= 0, debounced unchanged.
REQ-012 SHALL, when sync2 != debounced and counter < STABLE_CYCLES-1: counter <= counter+1.
REQ-013 SHALL, when sync2 != debounced and counter == STABLE_CYCLES-1: debounced <= sync2, counter <= 0, and the matching rise or fall bit <= 1 on that same edge.
REQ-014 SHALL drive rise[i] and fall[i] to 0 on every edge where REQ-013 does not apply; each pulse lasts exactly one cycle, and rise[i]/fall[i] are never 1 together.
REQ-015 SHALL give a clean step on raw_in latency of exactly STABLE_CYCLES+2 edges, counted from the first edge that samples the new level, to debounced changing.
REQ-016 SHALL reject any sync2 excursion shorter than STABLE_CYCLES cycles: counter restarts at 0 on return, with no output change and no pulse.
REQ-017 SHALL process channels fully independently; simultaneous transitions on several channels each complete on their own schedule, and any number of bits may pulse on the same edge.
REQ-018 SHALL with STABLE_CYCLES == 1 accept a changed sync2 level on the first differing edge.
REQ-019 SHALL contain no combinational path from raw_in to any output.

Reset
REQ-020 SHALL, when reset == 0 at a clock edge, set sync1, sync2, debounced, rise, fall and all counters to 0, overriding REQ-011..REQ-014.
REQ-021 SHALL, when reset is asserted mid-count, discard the partial count; after release the channel restarts from counter 0 with debounced == 0.
REQ-022 SHALL, when raw_in[i] is held at 1 through reset release, produce debounced[i] == 1 with one rise pulse, STABLE_CYCLES+2 edges after the first released edge.

Verification (bench uses WIDTH=3, STABLE_CYCLES=4)
REQ-023 SHALL cover a clean step: raw_in[0] 0->1 sampled at edge k -> debounced[0]=1 after edge k+5; rise[0]=1 for that cycle only; fall=000.
REQ-024 SHALL cover a glitch: raw_in[1]=1 for 3 cycles, then 0 -> debounced[1] stays 0; rise[1] and fall[1] stay 0 throughout.
REQ-025 SHALL cover bounce: raw_in[2] toggles 1,0,1,0,1 each cycle, then holds 1 -> debounced[2] rises exactly 6 edges after the final 0->1 sample; single rise pulse.
REQ-026 SHALL cover parallel channels: raw_in 000->111 on one edge -> debounced=111 and rise=111 on the same cycle; later 111->000 -> fall=111 for one cycle.
REQ-027 SHALL cover reset mid-count: raw_in[0]=1, reset=0 for one edge after 2 counted cycles -> all outputs 0; debounced[0] rises 6 edges after release.
REQ-028 SHALL cover held reset: reset=0 with raw_in=111 for 10 cycles -> debounced, rise and fall remain 000 for the whole interval.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Purpose: bundles the pad-side input and the filtered outputs of button_debouncer.
// Latency: none, wiring only.
// Backpressure: none, level signals with no handshake.
// Ports: raw_in (pad levels), debounced (filtered levels), rise/fall (one-cycle edge pulses).
interface button_debouncer_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // master: the board/pad side that drives raw_in and consumes the filtered result
  modport master (
    output raw_in,
    input  debounced,
    input  rise,
    input  fall
  );

  // slave: the debouncer itself
  modport slave (
    input  raw_in,
    output debounced,
    output rise,
    output fall
  );
endinterface

// File: rtl/button_debouncer.sv
// Purpose: per-channel 2-flop synchronizer plus stability counter that filters bouncing pads.
// Latency: a clean step reaches debounced STABLE_CYCLES+2 edges after it is first sampled.
// Backpressure: none, free-running; rise/fall are single-cycle pulses with no handshake.
// Ports: clock, reset (synchronous, active-low), bus.raw_in in; bus.debounced/rise/fall out (all registered).
module button_debouncer #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic              clock,
  input  logic              reset,
  button_debouncer_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // Terminal count: the edge on which the counter sits here and sync2 still
  // differs is the STABLE_CYCLES-th consecutive differing edge, so accept.
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]         sync1;
  logic [WIDTH-1:0]         sync2;
  logic [WIDTH-1:0]         deb_q;
  logic [WIDTH-1:0]         rise_q;
  logic [WIDTH-1:0]         fall_q;
  logic [WIDTH-1:0][CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= bus.raw_in;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        if (sync2[i] == deb_q[i]) begin
          // Level agrees with the output: any partial count was a glitch.
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          deb_q[i]  <= sync2[i];
          cnt[i]    <= '0;
          rise_q[i] <= sync2[i];
          fall_q[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.debounced = deb_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;

endmodule
